// File: rtl/mpu_store_writer_if.sv
// Bundle between the MPU store stage, the transfer controller and external memory.
// The writer uses the slave modport; whoever drives it uses master.
interface mpu_store_writer_if #(
  parameter int ADDR_W = 16,
  parameter int FP     = 16,
  parameter int MBITS  = 2,
  parameter int NBITS  = 2
);
  logic              start_in;
  logic [ADDR_W-1:0] base_addr_in;
  logic [MBITS:0]    m_size_in;
  logic [NBITS:0]    n_size_in;
  logic              store_en_in;
  logic [FP-1:0]     store_element_in;
  logic              store_ready_out;
  logic              mem_wr_valid_out;
  logic [ADDR_W-1:0] mem_wr_addr_out;
  logic [FP-1:0]     mem_wr_data_out;
  logic [MBITS:0]    mem_i_out;
  logic [NBITS:0]    mem_j_out;
  logic              mem_wr_ready_in;
  logic              busy_out;
  logic              done_out;
  logic              size_err_out;
  logic [1:0]        state_dbg;

  modport master (
    output start_in, base_addr_in, m_size_in, n_size_in, store_en_in, store_element_in,
           mem_wr_ready_in,
    input  store_ready_out, mem_wr_valid_out, mem_wr_addr_out, mem_wr_data_out,
           mem_i_out, mem_j_out, busy_out, done_out, size_err_out, state_dbg
  );

  modport slave (
    input  start_in, base_addr_in, m_size_in, n_size_in, store_en_in, store_element_in,
           mem_wr_ready_in,
    output store_ready_out, mem_wr_valid_out, mem_wr_addr_out, mem_wr_data_out,
           mem_i_out, mem_j_out, busy_out, done_out, size_err_out, state_dbg
  );
endinterface

// File: rtl/mpu_store_writer.sv
// Buffers the store-stage element stream in a small FIFO and issues it as row-major,
// contiguous memory writes. One matrix transfer at a time; done pulses after the last write.
module mpu_store_writer #(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 16,
  parameter int FP         = 16,
  parameter int MBITS      = 2,
  parameter int NBITS      = 2,
  parameter int M          = 4,
  parameter int N          = 4
) (
  input  logic clk,
  input  logic rst_n,
  mpu_store_writer_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = MBITS + NBITS + 2;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  localparam logic [MBITS:0] M_MAX = (MBITS+1)'(M);
  localparam logic [NBITS:0] N_MAX = (NBITS+1)'(N);

  // Handshakes: a transfer on either side happens on a rising edge where valid (or
  // store_en) and ready are both high; ready never depends combinationally on valid.
  logic [1:0]        state;
  logic [FP-1:0]     fifo_mem [FIFO_DEPTH];
  logic [AW:0]       wr_ptr, rd_ptr, occupancy;
  logic [ADDR_W-1:0] addr;
  logic [NBITS:0]    n_size;
  logic [MBITS:0]    row;
  logic [NBITS:0]    col;
  logic [TW-1:0]     total, accepted;
  logic              done_q, err_q;
  logic              fifo_empty, fifo_full, size_ok;
  logic              store_ready, wr_valid, push, pop, last_push, final_pop;

  assign occupancy  = wr_ptr - rd_ptr;
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign size_ok = (bus.m_size_in != '0) && (bus.m_size_in <= M_MAX) &&
                   (bus.n_size_in != '0) && (bus.n_size_in <= N_MAX);

  assign store_ready = (state == S_WRITE) && !fifo_full && (accepted < total);
  assign wr_valid    = (state != S_IDLE) && !fifo_empty;
  assign push        = bus.store_en_in && store_ready;
  assign pop         = wr_valid && bus.mem_wr_ready_in;
  assign last_push   = push && ((accepted + TW'(1)) == total);
  // In DRAIN no more pushes arrive, so the last buffered element is the final write.
  assign final_pop   = (state == S_DRAIN) && pop && (occupancy == (AW+1)'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      addr     <= '0;
      n_size   <= '0;
      row      <= '0;
      col      <= '0;
      total    <= '0;
      accepted <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start_in) begin
            if (size_ok) begin
              addr     <= bus.base_addr_in;
              n_size   <= bus.n_size_in;
              total    <= {{(NBITS+1){1'b0}}, bus.m_size_in} *
                          {{(MBITS+1){1'b0}}, bus.n_size_in};
              accepted <= '0;
              wr_ptr   <= '0;
              rd_ptr   <= '0;
              row      <= '0;
              col      <= '0;
              state    <= S_WRITE;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        S_WRITE: if (last_push) state <= S_DRAIN;
        S_DRAIN: begin
          if (final_pop) begin
            state  <= S_IDLE;
            done_q <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase

      if (push) begin
        wr_ptr   <= wr_ptr + (AW+1)'(1);
        accepted <= accepted + TW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + (AW+1)'(1);
        addr   <= addr + ADDR_W'(1);
        if (col == n_size - (NBITS+1)'(1)) begin
          col <= '0;
          row <= row + (MBITS+1)'(1);
        end else begin
          col <= col + (NBITS+1)'(1);
        end
      end
    end
  end

  // Storage needs no reset: data leaves only while the FIFO holds valid entries.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr[AW-1:0]] <= bus.store_element_in;
  end

  assign bus.store_ready_out  = store_ready;
  assign bus.mem_wr_valid_out = wr_valid;
  assign bus.mem_wr_addr_out  = addr;
  assign bus.mem_wr_data_out  = wr_valid ? fifo_mem[rd_ptr[AW-1:0]] : '0;
  assign bus.mem_i_out        = row;
  assign bus.mem_j_out        = col;
  assign bus.busy_out         = (state != S_IDLE);
  assign bus.done_out         = done_q;
  assign bus.size_err_out     = err_q;
  assign bus.state_dbg        = state;
endmodule

// File: tb/tb_mpu_store_writer.sv
// Randomized bench for mpu_store_writer: a queue-based transfer model predicts every
// output each cycle, and observed write sequences are pinned against literal tables.
module tb_mpu_store_writer;
  localparam int DEPTH = 4;

  logic clk;
  logic rst_n;

  mpu_store_writer_if #(.ADDR_W(16), .FP(16), .MBITS(2), .NBITS(2)) bus ();

  mpu_store_writer #(
    .FIFO_DEPTH(DEPTH), .ADDR_W(16), .FP(16), .MBITS(2), .NBITS(2), .M(4), .N(4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // transfer model: what the block must do, in terms of elements and write counts
  bit           m_active;
  int           m_base, m_total, m_n, m_pushed, m_wr;
  logic [15:0]  exp_q[$];
  bit           m_done, m_err;
  bit           took_elem;

  // observations for literal checks
  int obs_addr[$];
  int obs_ij[$];
  int done_cnt, err_cnt, stall_push;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_active = 0;
    m_total  = 0;
    m_pushed = 0;
    m_wr     = 0;
    exp_q.delete();
    m_done   = 0;
    m_err    = 0;
  endtask

  task automatic check_outputs();
    bit exp_valid, exp_ready;
    exp_valid = m_active && (exp_q.size() > 0);
    exp_ready = m_active && (exp_q.size() < DEPTH) && (m_pushed < m_total);
    chk("busy",     32'(bus.busy_out),         32'(m_active));
    chk("ready",    32'(bus.store_ready_out),  32'(exp_ready));
    chk("valid",    32'(bus.mem_wr_valid_out), 32'(exp_valid));
    chk("done",     32'(bus.done_out),         32'(m_done));
    chk("size_err", 32'(bus.size_err_out),     32'(m_err));
    if (exp_valid) begin
      chk("addr", 32'(bus.mem_wr_addr_out), 32'((m_base + m_wr) & 16'hFFFF));
      chk("i",    32'(bus.mem_i_out),       32'(m_wr / m_n));
      chk("j",    32'(bus.mem_j_out),       32'(m_wr % m_n));
      chk("data", 32'(bus.mem_wr_data_out), 32'(exp_q[0]));
    end
    if (bus.mem_wr_valid_out && bus.mem_wr_ready_in) begin
      obs_addr.push_back(int'(bus.mem_wr_addr_out));
      obs_ij.push_back(int'(bus.mem_i_out) * 16 + int'(bus.mem_j_out));
    end
    if (bus.done_out) done_cnt++;
    if (bus.size_err_out) err_cnt++;
    if (bus.store_en_in && bus.store_ready_out && !bus.mem_wr_ready_in) stall_push++;
  endtask

  task automatic model_step();
    bit nd, ne, exp_valid, exp_ready, pop, push;
    int m, n;
    nd = 0;
    ne = 0;
    took_elem = 0;
    if (!m_active) begin
      if (bus.start_in) begin
        m = int'(bus.m_size_in);
        n = int'(bus.n_size_in);
        if (m >= 1 && m <= 4 && n >= 1 && n <= 4) begin
          m_active = 1;
          m_base   = int'(bus.base_addr_in);
          m_n      = n;
          m_total  = m * n;
          m_pushed = 0;
          m_wr     = 0;
          exp_q.delete();
        end else begin
          ne = 1;
        end
      end
    end else begin
      exp_valid = exp_q.size() > 0;
      exp_ready = (exp_q.size() < DEPTH) && (m_pushed < m_total);
      pop  = exp_valid && bus.mem_wr_ready_in;
      push = exp_ready && bus.store_en_in;
      if (pop) begin
        void'(exp_q.pop_front());
        m_wr++;
        if (m_wr == m_total) begin
          m_active = 0;
          nd = 1;
        end
      end
      if (push) begin
        exp_q.push_back(bus.store_element_in);
        m_pushed++;
        took_elem = 1;
      end
    end
    m_done = nd;
    m_err  = ne;
  endtask

  task automatic cycle();
    check_outputs();
    model_step();
    @(posedge clk);
    #1;
    if (took_elem) bus.store_element_in = 16'($urandom);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ready"}, 32'(bus.store_ready_out),  32'd0);
    chk({tag, "_valid"}, 32'(bus.mem_wr_valid_out), 32'd0);
    chk({tag, "_addr"},  32'(bus.mem_wr_addr_out),  32'd0);
    chk({tag, "_data"},  32'(bus.mem_wr_data_out),  32'd0);
    chk({tag, "_i"},     32'(bus.mem_i_out),        32'd0);
    chk({tag, "_j"},     32'(bus.mem_j_out),        32'd0);
    chk({tag, "_busy"},  32'(bus.busy_out),         32'd0);
    chk({tag, "_done"},  32'(bus.done_out),         32'd0);
    chk({tag, "_err"},   32'(bus.size_err_out),     32'd0);
  endtask

  task automatic do_reset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero(tag);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // driver: one transfer, optional memory stall window, optional mid-transfer abort
  task automatic run_xfer(input int base, input int m, input int n, input int en_pct,
                          input int rdy_pct, input int stall, input int abort_after,
                          input bit poke_start);
    int cyc;
    obs_addr.delete();
    obs_ij.delete();
    done_cnt   = 0;
    err_cnt    = 0;
    stall_push = 0;
    bus.base_addr_in    = 16'(base);
    bus.m_size_in       = 3'(m);
    bus.n_size_in       = 3'(n);
    bus.store_en_in     = 1'b0;
    bus.mem_wr_ready_in = 1'b0;
    bus.start_in        = 1'b1;
    cycle();
    bus.start_in = 1'b0;
    cyc = 0;
    while (m_active && cyc < 2000) begin
      if (abort_after > 0 && obs_addr.size() >= abort_after) break;
      bus.store_en_in     = ($urandom_range(1, 100) <= en_pct);
      bus.mem_wr_ready_in = (cyc >= stall) && ($urandom_range(1, 100) <= rdy_pct);
      bus.start_in        = poke_start && ($urandom_range(0, 3) == 0);
      if (bus.start_in) begin
        bus.m_size_in    = 3'($urandom_range(0, 7));
        bus.n_size_in    = 3'($urandom_range(0, 7));
        bus.base_addr_in = 16'($urandom);
      end
      cycle();
      cyc++;
    end
    bus.start_in        = 1'b0;
    bus.store_en_in     = 1'b0;
    bus.mem_wr_ready_in = 1'b0;
    if (abort_after == 0) begin
      cycle();
      chk("xfer_finished", 32'(bus.busy_out), 32'd0);
    end
  endtask

  initial begin
    int exp_ij[6];
    int exp_wrap[4];
    exp_ij   = '{0, 1, 2, 16, 17, 18};
    exp_wrap = '{32'hFFFE, 32'hFFFF, 32'h0000, 32'h0001};

    rst_n                = 1'b1;
    bus.start_in         = 1'b0;
    bus.base_addr_in     = '0;
    bus.m_size_in        = '0;
    bus.n_size_in        = '0;
    bus.store_en_in      = 1'b0;
    bus.store_element_in = 16'($urandom);
    bus.mem_wr_ready_in  = 1'b0;
    model_reset();
    @(posedge clk);
    do_reset("reset");
    repeat (2) cycle();

    // 2x3 at 0x0100, everything flowing
    run_xfer(32'h0100, 2, 3, 100, 100, 0, 0, 0);
    chk("t1_writes", 32'(obs_addr.size()), 32'd6);
    for (int k = 0; k < 6 && k < obs_addr.size(); k++) begin
      chk("t1_addr", 32'(obs_addr[k]), 32'(32'h0100 + k));
      chk("t1_ij",   32'(obs_ij[k]),   32'(exp_ij[k]));
    end
    chk("t1_done_cnt", 32'(done_cnt), 32'd1);

    // 3x3 with memory stalled for 10 cycles: four pushes fill the buffer
    run_xfer(32'h0300, 3, 3, 100, 100, 10, 0, 0);
    chk("t2_stall_pushes", 32'(stall_push), 32'd4);
    chk("t2_writes", 32'(obs_addr.size()), 32'd9);

    // address wrap
    run_xfer(32'hFFFE, 1, 4, 100, 100, 0, 0, 0);
    chk("t3_writes", 32'(obs_addr.size()), 32'd4);
    for (int k = 0; k < 4 && k < obs_addr.size(); k++)
      chk("t3_addr", 32'(obs_addr[k]), 32'(exp_wrap[k]));

    // rejected sizes
    run_xfer(32'h0040, 0, 2, 100, 100, 0, 0, 0);
    chk("t4a_err_cnt", 32'(err_cnt), 32'd1);
    chk("t4a_writes", 32'(obs_addr.size()), 32'd0);
    run_xfer(32'h0040, 2, 5, 100, 100, 0, 0, 0);
    chk("t4b_err_cnt", 32'(err_cnt), 32'd1);
    chk("t4b_writes", 32'(obs_addr.size()), 32'd0);

    // 2x2, store_en held high, slow memory, stray starts while busy
    run_xfer(32'h0500, 2, 2, 100, 30, 0, 0, 1);
    chk("t5_writes", 32'(obs_addr.size()), 32'd4);
    chk("t5_err_cnt", 32'(err_cnt), 32'd0);

    // abort after three writes, then a 1x1 transfer
    run_xfer(32'h0200, 3, 3, 100, 100, 0, 3, 0);
    do_reset("abort");
    done_cnt = 0;
    repeat (3) cycle();
    chk("abort_no_done", 32'(done_cnt), 32'd0);
    run_xfer(32'h0777, 1, 1, 100, 100, 0, 0, 0);
    chk("t6_writes", 32'(obs_addr.size()), 32'd1);
    chk("t6_addr", 32'(obs_addr.size() > 0 ? obs_addr[0] : -1), 32'h0777);
    chk("t6_done_cnt", 32'(done_cnt), 32'd1);

    // random transfers
    for (int t = 0; t < 20; t++) begin
      run_xfer(int'($urandom_range(0, 65535)), int'($urandom_range(1, 4)),
               int'($urandom_range(1, 4)), int'($urandom_range(30, 100)),
               int'($urandom_range(30, 100)), int'($urandom_range(0, 6)), 0, 1);
      repeat (int'($urandom_range(0, 2))) cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mpu_store_writer.md
# mpu_store_writer

Downstream of the MPU store stage: accepts the matrix element stream leaving the store stage and writes it to external memory. Elements go into a small FIFO, are tagged with row/column position, and are issued as row-major, contiguous memory writes under a valid/ready handshake with the memory side. Exactly one matrix transfer is tracked at a time, and the block signals completion once the last element has been accepted by memory.

## Interface
Parameters:
- FIFO_DEPTH, 4, element buffer entries (power of two, ≥2)
- ADDR_W, 16, memory word address width
- FP, MBITS, NBITS, M, N: from global_defs (element width; row/column index widths; max rows/cols)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- start_in  in  1  one-cycle pulse: begin a transfer (sampled in IDLE only)
- base_addr_in  in  ADDR_W  first word address, latched on accepted start
- m_size_in  in  MBITS+1  matrix rows, latched on accepted start
- n_size_in  in  NBITS+1  matrix columns, latched on accepted start
- store_en_in  in  1  element valid from store stage
- store_element_in  in  FP  element data
- store_ready_out  out  1  writer can accept an element this cycle
- mem_wr_valid_out  out  1  write request valid
- mem_wr_addr_out  out  ADDR_W  write address
- mem_wr_data_out  out  FP  write data
- mem_i_out  out  MBITS+1  row index of current write
- mem_j_out  out  NBITS+1  column index of current write
- mem_wr_ready_in  in  1  memory accepts the write this cycle
- busy_out  out  1  state ≠ IDLE
- done_out  out  1  one-cycle pulse: final write accepted
- size_err_out  out  1  one-cycle pulse: start rejected

## Operation
- States: IDLE, WRITE, DRAIN.
- IDLE: on start_in, if 1 ≤ m_size_in ≤ M and 1 ≤ n_size_in ≤ N, latch base/m/n, set total = m*n, clear counters and FIFO, and go to WRITE. Otherwise pulse size_err_out and stay in IDLE.
- WRITE: store_ready_out = !fifo_full && (accepted < total). A push occurs when store_en_in && store_ready_out. store_en_in while not ready is ignored: the element is dropped, and the upstream stage must hold it.
- When a push makes accepted == total, the next state is DRAIN.
- DRAIN: store_ready_out = 0. Leave when the final write handshakes; the next state is IDLE and done_out pulses that cycle.
- Write side, in WRITE and DRAIN: mem_wr_valid_out = !fifo_empty. A write completes on mem_wr_valid_out && mem_wr_ready_in.
  - On each completed write: pop the FIFO; increment the address (mod 2^ADDR_W, wrap allowed).
  - j increments; when j == n-1, j → 0 and i increments.
- mem_wr_addr_out, mem_i_out and mem_j_out reflect the FIFO head element. These outputs, and mem_wr_data_out, hold stable while valid && !ready.
- A push and a pop in the same cycle are both allowed; occupancy is unchanged.
- start_in outside IDLE is ignored, with no error.
- total width: (MBITS+1)+(NBITS+1) bits, with no overflow.

## Timing
- Reset (async assert, synchronous deassert expected upstream): state IDLE, FIFO empty, counters 0.
  - All outputs 0, including mem_wr_addr_out, data, i and j.
- Reset mid-transfer aborts immediately: buffered elements are discarded and no done_out is issued.
- start accepted at edge k: busy_out = 1 and store_ready_out = 1 after edge k.
- Push-to-valid latency is 1 cycle: an element pushed at edge k gives mem_wr_valid_out = 1 after edge k.
- With mem_wr_ready_in held at 1 and store_en_in held at 1, throughput is 1 element per cycle.
- done_out is high for the cycle after the final write handshake edge. busy_out falls on that same edge.
- Once full, store_ready_out stays low until the pop that frees an entry. Ready recovers in the cycle after the pop edge.

## Test plan
- m=2, n=3, base=0x0100, store_en_in continuous, mem ready always high → six writes at addresses 0x0100–0x0105 with (i,j) = (0,0),(0,1),(0,2),(1,0),(1,1),(1,2). done_out pulses once, one cycle after the 6th write.
- FIFO_DEPTH=4, m=n=3, mem_wr_ready_in low for 10 cycles → store_ready_out drops after 4 pushes. Addr/data hold steady while stalled. After ready rises, all 9 elements arrive in order with no loss.
- base=0xFFFE, m=1, n=4 → addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- start with m=0; with n=N+1 → size_err_out pulse, busy_out stays 0, no writes.
- store_en_in held high after the 4th push of a 2×2 transfer → store_ready_out = 0, and extra elements are not written. start_in during busy is ignored.
- rst_n pulsed low after 3 of 9 writes → outputs are 0 immediately. A subsequent transfer with m=n=1 completes normally.
